ssm_tile_scheduler: RTL and testbench

- Generalised successor to the SSM tile packer. Walks a full SSM step over batch, head-tile and P-tile axes, and drives an external tile compute core (ssm_block_fp16_top or later) through a start/done handshake.
- Slices per-tile operands from the full flat buffers and scatters each returned y tile into the full output.
- New relative to the packer:
  - batch looping
  - $clog2-sized counters of any depth
  - selectable loop order
  - abort
  - busy/tile-index status
  - optional core timeout

---
 rtl/ssm_tile_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_ssm_tile_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ssm_tile_scheduler.sv
// ssm_tile_scheduler: walks one SSM step over batch, head-tile and P-tile
// axes, slicing per-tile operands out of the flat buffers, handshaking each
// tile with an external compute core (core_start/core_done), and scattering
// every returned y tile into y_flat_out.
// Ports: clk/rst (sync, active high); start/order/abort control;
// busy/done/err/tile_idx status; *_flat_in full operand buffers;
// y_flat_out assembled result; core_* handshake; *_tile per-tile operands;
// y_tile core result.
// Optional feature macro: SCHED_TIMEOUT_EN (core_done wait limit, sets err).
module ssm_tile_scheduler #(
  parameter int B           = 1,
  parameter int H           = 24,
  parameter int P           = 64,
  parameter int N           = 128,
  parameter int H_TILE      = 12,
  parameter int P_TILE      = 16,
  parameter int DW          = 16,
  parameter int TIMEOUT_CYC = 4096,
  localparam int T          = B * (H / H_TILE) * (P / P_TILE),
  localparam int TIW        = $clog2(T + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          order,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [TIW-1:0]                tile_idx,
  input  logic [B*H*DW-1:0]             dt_flat_in,
  input  logic [B*H*DW-1:0]             dA_flat_in,
  input  logic [B*N*DW-1:0]             Bmat_flat_in,
  input  logic [B*N*DW-1:0]             C_flat_in,
  input  logic [H*DW-1:0]               D_flat_in,
  input  logic [B*H*P*DW-1:0]           x_flat_in,
  input  logic [B*H*P*N*DW-1:0]         h_prev_flat_in,
  output logic [B*H*P*DW-1:0]           y_flat_out,
  output logic                          core_start,
  input  logic                          core_done,
  output logic [H_TILE*DW-1:0]          dt_tile,
  output logic [H_TILE*DW-1:0]          dA_tile,
  output logic [H_TILE*DW-1:0]          D_tile,
  output logic [N*DW-1:0]               Bmat_tile,
  output logic [N*DW-1:0]               C_tile,
  output logic [H_TILE*P_TILE*DW-1:0]   x_tile,
  output logic [H_TILE*P_TILE*N*DW-1:0] h_prev_tile,
  input  logic [H_TILE*P_TILE*DW-1:0]   y_tile
);

  localparam int HT = H / H_TILE;
  localparam int PT = P / P_TILE;
  localparam int BW = (B  > 1) ? $clog2(B)  : 1;
  localparam int HW = (HT > 1) ? $clog2(HT) : 1;
  localparam int PW = (PT > 1) ? $clog2(PT) : 1;
  localparam logic [BW-1:0]  B_LAST = BW'(B - 1);
  localparam logic [HW-1:0]  H_LAST = HW'(HT - 1);
  localparam logic [PW-1:0]  P_LAST = PW'(PT - 1);
  localparam logic [TIW-1:0] T_LAST = TIW'(T - 1);

  if (H % H_TILE != 0) begin : g_bad_h
    $error("H must be a multiple of H_TILE");
  end
  if (P % P_TILE != 0) begin : g_bad_p
    $error("P must be a multiple of P_TILE");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_to
    $error("TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         b_q, b_d;
  logic [HW-1:0]         h_q, h_d;
  logic [PW-1:0]         p_q, p_d;
  logic                  order_q, order_d;
  logic [TIW-1:0]        tile_q, tile_d;
  logic [B*H*P*DW-1:0]   y_q, y_d;
  logic                  core_start_q, core_start_d;
  logic                  done_q, done_d;
  logic                  capture;
  logic [31:0]           b_i, h_i, p_i;

`ifdef SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  logic          err_q, err_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign b_i = 32'(b_q);
  assign h_i = 32'(h_q);
  assign p_i = 32'(p_q);

  // Operand slices depend only on registered indices, so they hold from
  // ISSUE through the capture cycle.
  always_comb begin
    dt_tile     = '0;
    dA_tile     = '0;
    D_tile      = '0;
    Bmat_tile   = '0;
    C_tile      = '0;
    x_tile      = '0;
    h_prev_tile = '0;
    for (int unsigned hr = 0; hr < H_TILE; hr++) begin
      dt_tile[hr*DW +: DW] = dt_flat_in[(b_i*H + h_i*H_TILE + hr)*DW +: DW];
      dA_tile[hr*DW +: DW] = dA_flat_in[(b_i*H + h_i*H_TILE + hr)*DW +: DW];
      D_tile[hr*DW +: DW]  = D_flat_in[(h_i*H_TILE + hr)*DW +: DW];
      for (int unsigned pr = 0; pr < P_TILE; pr++) begin
        x_tile[(hr*P_TILE + pr)*DW +: DW] =
          x_flat_in[((b_i*H + h_i*H_TILE + hr)*P + p_i*P_TILE + pr)*DW +: DW];
        for (int unsigned n = 0; n < N; n++) begin
          h_prev_tile[((hr*P_TILE + pr)*N + n)*DW +: DW] =
            h_prev_flat_in[(((b_i*H + h_i*H_TILE + hr)*P + p_i*P_TILE + pr)*N + n)*DW +: DW];
        end
      end
    end
    for (int unsigned n = 0; n < N; n++) begin
      Bmat_tile[n*DW +: DW] = Bmat_flat_in[(b_i*N + n)*DW +: DW];
      C_tile[n*DW +: DW]    = C_flat_in[(b_i*N + n)*DW +: DW];
    end
  end

  always_comb begin
    state_d      = state_q;
    b_d          = b_q;
    h_d          = h_q;
    p_d          = p_q;
    order_d      = order_q;
    tile_d       = tile_q;
    core_start_d = 1'b0;
    done_d       = 1'b0;
    capture      = 1'b0;
`ifdef SCHED_TIMEOUT_EN
    err_d        = err_q;
    wcnt_d       = wcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          order_d      = order;
          b_d          = '0;
          h_d          = '0;
          p_d          = '0;
          tile_d       = '0;
          core_start_d = 1'b1;
          state_d      = S_ISSUE;
`ifdef SCHED_TIMEOUT_EN
          err_d        = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
        state_d = abort ? S_IDLE : S_WAIT;
`ifdef SCHED_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (core_done) begin
          capture = 1'b1;
          tile_d  = tile_q + 1'b1;
          // Batch is always outermost; order picks which of p/h spins fastest.
          if (!order_q) begin
            p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
            if (p_q == P_LAST) begin
              h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
              if (h_q == H_LAST) b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
            end
          end else begin
            h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
            if (h_q == H_LAST) begin
              p_d = (p_q == P_LAST) ? '0 : p_q + 1'b1;
              if (p_q == P_LAST) b_d = (b_q == B_LAST) ? '0 : b_q + 1'b1;
            end
          end
          if (tile_q == T_LAST) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d      = S_ISSUE;
            core_start_d = 1'b1;
          end
`ifdef SCHED_TIMEOUT_EN
        end else if (wcnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    y_d = y_q;
    if (capture) begin
      for (int unsigned hr = 0; hr < H_TILE; hr++) begin
        for (int unsigned pr = 0; pr < P_TILE; pr++) begin
          y_d[((b_i*H + h_i*H_TILE + hr)*P + p_i*P_TILE + pr)*DW +: DW] =
            y_tile[(hr*P_TILE + pr)*DW +: DW];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      b_q          <= '0;
      h_q          <= '0;
      p_q          <= '0;
      order_q      <= 1'b0;
      tile_q       <= '0;
      y_q          <= '0;
      core_start_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef SCHED_TIMEOUT_EN
      err_q        <= 1'b0;
      wcnt_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      b_q          <= b_d;
      h_q          <= h_d;
      p_q          <= p_d;
      order_q      <= order_d;
      tile_q       <= tile_d;
      y_q          <= y_d;
      core_start_q <= core_start_d;
      done_q       <= done_d;
`ifdef SCHED_TIMEOUT_EN
      err_q        <= err_d;
      wcnt_q       <= wcnt_d;
`endif
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign core_start = core_start_q;
  assign tile_idx   = tile_q;
  assign y_flat_out = y_q;

endmodule

// File: tb/tb_ssm_tile_scheduler.sv
module tb_ssm_tile_scheduler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, start = 1'b0, order = 1'b0, abort = 1'b0;
  logic core_en = 1'b1;
  int   n_cmp = 0, n_bad = 0;

  // DUT 1: B=1 (T=4)
  logic         busy1, done1, err1, cs1, cd1;
  logic [2:0]   tidx1;
  logic [31:0]  dt1, dA1, D1;
  logic [15:0]  bm1, c1;
  logic [127:0] x1, y1;
  logic [255:0] hp1;
  logic [15:0]  dtt1, dAt1, Dt1, bmt1, ct1;
  logic [31:0]  xt1, yt1;
  logic [63:0]  hpt1;

  // DUT 2: B=2 (T=8)
  logic         busy2, done2, err2, cs2, cd2;
  logic [3:0]   tidx2;
  logic [63:0]  dt2, dA2;
  logic [31:0]  bm2, c2;
  logic [255:0] x2, y2;
  logic [511:0] hp2;
  logic [15:0]  dtt2, dAt2, Dt2, bmt2, ct2;
  logic [31:0]  xt2, yt2;
  logic [63:0]  hpt2;

  ssm_tile_scheduler #(.B(1), .H(4), .P(4), .N(2), .H_TILE(2), .P_TILE(2), .DW(8), .TIMEOUT_CYC(5)) dut1 (
    .clk(clk), .rst(rst), .start(start), .order(order), .abort(abort),
    .busy(busy1), .done(done1), .err(err1), .tile_idx(tidx1),
    .dt_flat_in(dt1), .dA_flat_in(dA1), .Bmat_flat_in(bm1), .C_flat_in(c1), .D_flat_in(D1),
    .x_flat_in(x1), .h_prev_flat_in(hp1), .y_flat_out(y1),
    .core_start(cs1), .core_done(cd1),
    .dt_tile(dtt1), .dA_tile(dAt1), .D_tile(Dt1), .Bmat_tile(bmt1), .C_tile(ct1),
    .x_tile(xt1), .h_prev_tile(hpt1), .y_tile(yt1));

  ssm_tile_scheduler #(.B(2), .H(4), .P(4), .N(2), .H_TILE(2), .P_TILE(2), .DW(8), .TIMEOUT_CYC(5)) dut2 (
    .clk(clk), .rst(rst), .start(start), .order(order), .abort(abort),
    .busy(busy2), .done(done2), .err(err2), .tile_idx(tidx2),
    .dt_flat_in(dt2), .dA_flat_in(dA2), .Bmat_flat_in(bm2), .C_flat_in(c2), .D_flat_in(D1),
    .x_flat_in(x2), .h_prev_flat_in(hp2), .y_flat_out(y2),
    .core_start(cs2), .core_done(cd2),
    .dt_tile(dtt2), .dA_tile(dAt2), .D_tile(Dt2), .Bmat_tile(bmt2), .C_tile(ct2),
    .x_tile(xt2), .h_prev_tile(hpt2), .y_tile(yt2));

  // Core model: latency 3, y = x + 1 per element.
  logic [2:0] pipe1 = '0, pipe2 = '0;
  always @(posedge clk) begin
    pipe1 <= {pipe1[1:0], cs1};
    pipe2 <= {pipe2[1:0], cs2};
  end
  assign cd1 = pipe1[2] & core_en;
  assign cd2 = pipe2[2] & core_en;
  always_comb begin
    yt1 = '0;
    yt2 = '0;
    for (int i = 0; i < 4; i++) begin
      yt1[i*8 +: 8] = xt1[i*8 +: 8] + 8'd1;
      yt2[i*8 +: 8] = xt2[i*8 +: 8] + 8'd1;
    end
  end

  // Per-cycle records of the last run
  bit          cs_h[0:40], done_h[0:40], busy_h[0:40], err_h[0:40];
  bit          cs2_h[0:40], done2_h[0:40];
  logic [31:0] xi[0:7];
  logic [15:0] dti[0:7], di[0:7], bm2i[0:7], dt2i[0:7];
  logic [63:0] hpi[0:7];
  int          ni, n2;
  logic [255:0] exp_y;

  function automatic int count(input bit a[0:40]);
    int s = 0;
    for (int i = 0; i <= 40; i++) s += int'(a[i]);
    return s;
  endfunction

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // start is driven in cycle 0; cycle c is the period after the c-th following edge.
  task automatic run(input logic ord, input int ncyc, input int extra, input int ab, input int rc);
    for (int i = 0; i <= 40; i++) begin
      cs_h[i] = 0; done_h[i] = 0; busy_h[i] = 0; err_h[i] = 0; cs2_h[i] = 0; done2_h[i] = 0;
    end
    ni = 0; n2 = 0;
    order = ord; start = 1'b1; abort = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk); #1;
      cs_h[c] = cs1; done_h[c] = done1; busy_h[c] = busy1; err_h[c] = err1;
      cs2_h[c] = cs2; done2_h[c] = done2;
      if (cs1 && ni < 8) begin
        xi[ni] = xt1; dti[ni] = dtt1; di[ni] = Dt1; hpi[ni] = hpt1; ni++;
      end
      if (cs2 && n2 < 8) begin
        bm2i[n2] = bmt2; dt2i[n2] = dtt2; n2++;
      end
      start = (c == extra) || (c == ab);
      abort = (c == ab);
      rst   = (c == rc);
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if ({busy1, done1, err1, cs1, tidx1} !== 7'd0) begin n_bad++; $display("FAIL reset_status1: got %b want 0", {busy1, done1, err1, cs1, tidx1}); end
    n_cmp++; if (y1 !== '0) begin n_bad++; $display("FAIL reset_y1: got %h want 0", y1); end
    n_cmp++; if ({busy2, done2, err2, cs2, tidx2} !== 8'd0) begin n_bad++; $display("FAIL reset_status2: got %b want 0", {busy2, done2, err2, cs2, tidx2}); end
  endtask

  task automatic test_basic();
    do_reset();
    run(1'b0, 20, -1, -1, -1);
    n_cmp++; if (!(cs_h[1] && cs_h[5] && cs_h[9] && cs_h[13]) || count(cs_h) != 4) begin n_bad++; $display("FAIL basic_core_start: got count %0d want 4 at 1,5,9,13", count(cs_h)); end
    n_cmp++; if (done_h[17] !== 1'b1 || count(done_h) != 1) begin n_bad++; $display("FAIL basic_done_cycle: got done17=%0d count %0d want 1/1", done_h[17], count(done_h)); end
    n_cmp++; if (busy_h[1] !== 1'b1 || busy_h[18] !== 1'b0) begin n_bad++; $display("FAIL basic_busy: got %0d/%0d want 1/0", busy_h[1], busy_h[18]); end
    n_cmp++; if (xi[1] !== 32'h07060302) begin n_bad++; $display("FAIL basic_x_tile1: got %h want 07060302", xi[1]); end
    n_cmp++; if (hpi[1] !== 64'h0F0E0D0C07060504) begin n_bad++; $display("FAIL basic_hprev_tile1: got %h want 0f0e0d0c07060504", hpi[1]); end
    n_cmp++; if (dti[2] !== 16'h0D0C || di[2] !== 16'h1716) begin n_bad++; $display("FAIL basic_dt_D_tile2: got %h %h want 0d0c 1716", dti[2], di[2]); end
    exp_y = '0;
    for (int k = 0; k < 16; k++) exp_y[k*8 +: 8] = 8'(k + 1);
    n_cmp++; if (y1 !== exp_y[127:0]) begin n_bad++; $display("FAIL basic_y: got %h want %h", y1, exp_y[127:0]); end
    n_cmp++; if (tidx1 !== 3'd4) begin n_bad++; $display("FAIL basic_tile_idx: got %0d want 4", tidx1); end
  endtask

  task automatic test_order1();
    do_reset();
    run(1'b1, 20, -1, -1, -1);
    n_cmp++; if ({xi[0][7:0], xi[1][7:0], xi[2][7:0], xi[3][7:0]} !== 32'h0008020A) begin n_bad++; $display("FAIL order1_sequence: got %h %h %h %h want 00 08 02 0a", xi[0][7:0], xi[1][7:0], xi[2][7:0], xi[3][7:0]); end
    n_cmp++; if (xi[1] !== 32'h0D0C0908) begin n_bad++; $display("FAIL order1_x_tile1: got %h want 0d0c0908", xi[1]); end
    n_cmp++; if (done_h[17] !== 1'b1) begin n_bad++; $display("FAIL order1_done: got %0d want 1", done_h[17]); end
    exp_y = '0;
    for (int k = 0; k < 16; k++) exp_y[k*8 +: 8] = 8'(k + 1);
    n_cmp++; if (y1 !== exp_y[127:0]) begin n_bad++; $display("FAIL order1_y: got %h want %h", y1, exp_y[127:0]); end
  endtask

  task automatic test_batch();
    do_reset();
    run(1'b0, 36, -1, -1, -1);
    n_cmp++; if (cs2_h[17] !== 1'b1 || count(cs2_h) != 8) begin n_bad++; $display("FAIL batch_issue5: got %0d count %0d want 1/8", cs2_h[17], count(cs2_h)); end
    n_cmp++; if (bm2i[3] !== 16'h1F1E || bm2i[4] !== 16'h3332) begin n_bad++; $display("FAIL batch_bmat_tile: got %h %h want 1f1e 3332", bm2i[3], bm2i[4]); end
    n_cmp++; if (dt2i[4] !== 16'h0F0E) begin n_bad++; $display("FAIL batch_dt_tile: got %h want 0f0e", dt2i[4]); end
    n_cmp++; if (done2_h[33] !== 1'b1 || count(done2_h) != 1) begin n_bad++; $display("FAIL batch_done: got %0d count %0d want 1/1", done2_h[33], count(done2_h)); end
    exp_y = '0;
    for (int k = 0; k < 16; k++) begin
      exp_y[k*8 +: 8]      = 8'(k + 1);
      exp_y[(16+k)*8 +: 8] = 8'(101 + k);
    end
    n_cmp++; if (y2 !== exp_y) begin n_bad++; $display("FAIL batch_y: got %h want %h", y2, exp_y); end
    n_cmp++; if (tidx2 !== 4'd8) begin n_bad++; $display("FAIL batch_tile_idx: got %0d want 8", tidx2); end
  endtask

  task automatic test_abort();
    do_reset();
    run(1'b0, 20, -1, 7, -1);
    n_cmp++; if (busy_h[7] !== 1'b1 || busy_h[8] !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got busy7=%0d busy8=%0d want 1/0", busy_h[7], busy_h[8]); end
    n_cmp++; if (count(done_h) != 0 || count(cs_h) != 2) begin n_bad++; $display("FAIL abort_no_done: got done %0d starts %0d want 0/2", count(done_h), count(cs_h)); end
    exp_y = '0;
    exp_y[0 +: 8] = 8'd1; exp_y[8 +: 8] = 8'd2; exp_y[32 +: 8] = 8'd5; exp_y[40 +: 8] = 8'd6;
    n_cmp++; if (y1 !== exp_y[127:0]) begin n_bad++; $display("FAIL abort_y: got %h want %h", y1, exp_y[127:0]); end
    n_cmp++; if (tidx1 !== 3'd1) begin n_bad++; $display("FAIL abort_tile_idx: got %0d want 1", tidx1); end
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    n_cmp++; if (busy1 !== 1'b0 || cs1 !== 1'b0) begin n_bad++; $display("FAIL abort_wins_idle: got busy=%0d cs=%0d want 0/0", busy1, cs1); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    run(1'b0, 20, 3, -1, -1);
    n_cmp++; if (done_h[17] !== 1'b1 || count(done_h) != 1 || count(cs_h) != 4) begin n_bad++; $display("FAIL busy_start_ignored: got done17=%0d done %0d starts %0d want 1/1/4", done_h[17], count(done_h), count(cs_h)); end
    do_reset();
    run(1'b0, 11, -1, -1, 10);
    n_cmp++; if (busy_h[10] !== 1'b1) begin n_bad++; $display("FAIL rst_mid_busy_before: got %0d want 1", busy_h[10]); end
    n_cmp++; if ({busy1, done1, err1, cs1, tidx1} !== 7'd0 || y1 !== '0) begin n_bad++; $display("FAIL rst_mid_clear: got %b y=%h want 0", {busy1, done1, err1, cs1, tidx1}, y1); end
  endtask

  task automatic test_timeout();
    core_en = 1'b0;
    do_reset();
`ifdef SCHED_TIMEOUT_EN
    run(1'b0, 8, -1, -1, -1);
    n_cmp++; if (err_h[7] !== 1'b1 || done_h[7] !== 1'b1) begin n_bad++; $display("FAIL timeout_err_done: got err=%0d done=%0d want 1/1", err_h[7], done_h[7]); end
    n_cmp++; if (busy_h[8] !== 1'b0 || err1 !== 1'b1) begin n_bad++; $display("FAIL timeout_idle_sticky: got busy=%0d err=%0d want 0/1", busy_h[8], err1); end
    core_en = 1'b1;
    run(1'b0, 20, -1, -1, -1);
    n_cmp++; if (err_h[1] !== 1'b0 || done_h[17] !== 1'b1) begin n_bad++; $display("FAIL timeout_err_cleared: got err=%0d done=%0d want 0/1", err_h[1], done_h[17]); end
`else
    run(1'b0, 25, -1, -1, -1);
    n_cmp++; if (busy_h[25] !== 1'b1 || count(done_h) != 0 || count(err_h) != 0) begin n_bad++; $display("FAIL no_answer_wait: got busy=%0d done %0d err %0d want 1/0/0", busy_h[25], count(done_h), count(err_h)); end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    n_cmp++; if (busy1 !== 1'b0 || tidx1 !== 3'd0) begin n_bad++; $display("FAIL no_answer_abort: got busy=%0d tile_idx=%0d want 0/0", busy1, tidx1); end
`endif
    core_en = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      dt1[i*8 +: 8] = 8'(10 + i); dA1[i*8 +: 8] = 8'(60 + i); D1[i*8 +: 8] = 8'(20 + i);
    end
    for (int i = 0; i < 8; i++) begin
      dt2[i*8 +: 8] = 8'(10 + i); dA2[i*8 +: 8] = 8'(60 + i);
    end
    bm1 = 16'h1F1E; c1 = 16'h2928;
    bm2 = 32'h33321F1E; c2 = 32'h3D3C2928;
    for (int k = 0; k < 16; k++) begin
      x1[k*8 +: 8] = 8'(k); x2[k*8 +: 8] = 8'(k); x2[(16+k)*8 +: 8] = 8'(100 + k);
    end
    for (int j = 0; j < 32; j++) begin
      hp1[j*8 +: 8] = 8'(j); hp2[j*8 +: 8] = 8'(j); hp2[(32+j)*8 +: 8] = 8'(128 + j);
    end
    test_reset();
    test_basic();
    test_order1();
    test_batch();
    test_abort();
    test_back_to_back();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
